// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the FIR datapath blocks: coefficient BRAM depth,
// byte-address width and the requester identifier used by the BRAM arbiter.
package fir_pkg;

    localparam int TAP_WORDS = 12;
    localparam int ADDR_W    = 12;

    typedef enum logic [1:0] {
        RQ_NONE = 2'd0,
        RQ_CFG  = 2'd1,
        RQ_ENG  = 2'd2
    } requester_t;

endpackage

// File: rtl/tap_bram_arbiter.sv
// tap_bram_arbiter
// Shares the single port of the coefficient BRAM between the host-side
// configuration requester (read/write) and the FIR engine (read-only tap
// fetch). One access is granted per cycle. Read data returns one cycle after
// the grant because of the BRAM read latency. Addresses are range-checked, and
// cfg writes are refused while the engine holds the lock.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   lock                      engine running; cfg writes not granted
//   cfg_req/we/addr/wdata     cfg request (we == 0 means read)
//   cfg_gnt                   cfg access accepted this cycle
//   cfg_rvalid/rdata/err      cfg return (write ack returns rdata 0)
//   eng_req/addr              engine read request
//   eng_gnt                   engine access accepted this cycle
//   eng_rvalid/rdata          engine return
//   bram_EN/WE/A/Di           BRAM port outputs
//   bram_Do                   BRAM read data (gated by bram_EN)
module tap_bram_arbiter
    import fir_pkg::*;
#(
    parameter int WORDS = TAP_WORDS,
    parameter int AW    = ADDR_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          lock,
    input  logic          cfg_req,
    input  logic [3:0]    cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic          cfg_gnt,
    output logic          cfg_rvalid,
    output logic [31:0]   cfg_rdata,
    output logic          cfg_err,
    input  logic          eng_req,
    input  logic [AW-1:0] eng_addr,
    output logic          eng_gnt,
    output logic          eng_rvalid,
    output logic [31:0]   eng_rdata,
    output logic          bram_EN,
    output logic [3:0]    bram_WE,
    output logic [AW-1:0] bram_A,
    output logic [31:0]   bram_Di,
    input  logic [31:0]   bram_Do
);

    // Word index past the end, or a non word-aligned byte address.
    function automatic logic out_of_range(input logic [AW-1:0] addr);
        return ({2'b00, addr[AW-1:2]} >= AW'(WORDS)) || (addr[1:0] != 2'b00);
    endfunction

    requester_t last_q, last_d;
    requester_t rsel_q, rsel_d;
    logic       rbad_q, rbad_d;
    logic       rwr_q,  rwr_d;

    logic cfg_elig, eng_elig;
    logic cfg_bad,  eng_bad;
    logic ret_live;

    always_comb begin
        cfg_elig   = cfg_req && !(lock && (cfg_we != 4'b0000));
        eng_elig   = eng_req;
        cfg_bad    = out_of_range(cfg_addr);
        eng_bad    = out_of_range(eng_addr);

        cfg_gnt    = 1'b0;
        eng_gnt    = 1'b0;
        bram_WE    = 4'b0000;
        bram_A     = '0;
        bram_Di    = 32'h0;
        last_d     = last_q;
        rsel_d     = RQ_NONE;
        rbad_d     = 1'b0;
        rwr_d      = 1'b0;

        // Grants are suppressed during reset so every output reads 0.
        if (!RST) begin
            if (cfg_elig && eng_elig) begin
                // Round-robin: whoever did not win last time goes first.
                if (last_q == RQ_ENG) cfg_gnt = 1'b1;
                else                  eng_gnt = 1'b1;
            end else if (eng_elig) begin
                eng_gnt = 1'b1;
            end else if (cfg_elig) begin
                cfg_gnt = 1'b1;
            end
        end

        if (cfg_gnt) begin
            bram_A  = cfg_addr;
            bram_Di = cfg_wdata;
            // A bad address must never corrupt RAM; the access still completes.
            bram_WE = cfg_bad ? 4'b0000 : cfg_we;
            last_d  = RQ_CFG;
            rsel_d  = RQ_CFG;
            rbad_d  = cfg_bad;
            rwr_d   = (cfg_we != 4'b0000);
        end else if (eng_gnt) begin
            bram_A  = eng_addr;
            last_d  = RQ_ENG;
            rsel_d  = RQ_ENG;
            rbad_d  = eng_bad;
        end

        // A return cycle is cancelled outright by reset.
        ret_live   = !RST && (rsel_q != RQ_NONE);

        // EN stays high in the return cycle, otherwise the BRAM gates Do to 0.
        bram_EN    = cfg_gnt || eng_gnt || ret_live;

        cfg_rvalid = ret_live && (rsel_q == RQ_CFG);
        eng_rvalid = ret_live && (rsel_q == RQ_ENG);
        cfg_err    = cfg_rvalid && rbad_q;
        // Write acknowledges and bad addresses return zero data.
        cfg_rdata  = (cfg_rvalid && !rbad_q && !rwr_q) ? bram_Do : 32'h0;
        eng_rdata  = (eng_rvalid && !rbad_q) ? bram_Do : 32'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= RQ_CFG;
            rsel_q <= RQ_NONE;
            rbad_q <= 1'b0;
            rwr_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            rsel_q <= rsel_d;
            rbad_q <= rbad_d;
            rwr_q  <= rwr_d;
        end
    end

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// tb_tap_bram_arbiter
// Directed stimulus against tap_bram_arbiter with a behavioural 12-word BRAM
// behind it. The stimulus process checks grants and BRAM port values
// mid-cycle and queues the hand-computed return for each expected grant. A
// monitor on the falling edge pops and checks every rvalid.
module tb_tap_bram_arbiter;
    import fir_pkg::*;

    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RST;
    logic          lock;
    logic          cfg_req;
    logic [3:0]    cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          cfg_gnt, cfg_rvalid, cfg_err;
    logic [31:0]   cfg_rdata;
    logic          eng_req;
    logic [AW-1:0] eng_addr;
    logic          eng_gnt, eng_rvalid;
    logic [31:0]   eng_rdata;
    logic          bram_EN;
    logic [3:0]    bram_WE;
    logic [AW-1:0] bram_A;
    logic [31:0]   bram_Di;
    logic [31:0]   bram_Do;

    always #5 CLK = ~CLK;

    tap_bram_arbiter #(.WORDS(12), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .lock(lock),
        .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
        .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
        .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_A(bram_A), .bram_Di(bram_Di),
        .bram_Do(bram_Do)
    );

    // Behavioural BRAM: registered address, byte writes, Do gated by EN.
    // Word i resets to 0x1000_0000 + i.
    logic [31:0]   mem [12];
    logic [AW-1:0] a_q;

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 12; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            a_q <= '0;
        end else if (bram_EN) begin
            a_q <= bram_A;
            if (bram_A[AW-1:2] < 10'd12)
                for (int b = 0; b < 4; b++)
                    if (bram_WE[b]) mem[bram_A[5:2]][8*b +: 8] <= bram_Di[8*b +: 8];
        end
    end

    assign bram_Do = (bram_EN && (a_q[AW-1:2] < 10'd12)) ? mem[a_q[5:2]] : 32'h0;

    int cyc = 0;
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    typedef struct {
        int          rcyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t cfg_sb[$];
    exp_t eng_sb[$];

    int total = 0;
    int bad   = 0;
    int eg_seen = 0;
    int cg_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every return is matched against the oldest queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            check("rvalid_under_reset", {30'b0, cfg_rvalid, eng_rvalid}, 32'h0);
        end else begin
            if (cfg_rvalid) begin
                if (cfg_sb.size() == 0) begin
                    check("cfg_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = cfg_sb.pop_front();
                    check("cfg_return_cycle", 32'(cyc), 32'(e.rcyc));
                    check("cfg_rdata", cfg_rdata, e.data);
                    check("cfg_err", 32'(cfg_err), 32'(e.err));
                end
            end else begin
                check("cfg_idle_err", 32'(cfg_err), 32'h0);
                check("cfg_idle_rdata", cfg_rdata, 32'h0);
            end
            if (eng_rvalid) begin
                if (eng_sb.size() == 0) begin
                    check("eng_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = eng_sb.pop_front();
                    check("eng_return_cycle", 32'(cyc), 32'(e.rcyc));
                    check("eng_rdata", eng_rdata, e.data);
                end
            end else begin
                check("eng_idle_rdata", eng_rdata, 32'h0);
            end
        end
    end

    // One cycle: drive inputs, check grants/BRAM port mid-cycle, queue returns.
    task automatic do_cycle(input logic er, input logic [AW-1:0] ea,
                            input logic cr, input logic [3:0] cwe,
                            input logic [AW-1:0] ca, input logic [31:0] cwd,
                            input logic lk,
                            input logic x_eg, input logic x_cg,
                            input logic [31:0] x_ed, input logic [31:0] x_cd,
                            input logic x_cerr, input logic [3:0] x_we);
        exp_t e;
        eng_req = er; eng_addr = ea;
        cfg_req = cr; cfg_we = cwe; cfg_addr = ca; cfg_wdata = cwd;
        lock = lk;
        #3;
        check("eng_gnt", 32'(eng_gnt), 32'(x_eg));
        check("cfg_gnt", 32'(cfg_gnt), 32'(x_cg));
        if (eng_gnt) eg_seen++;
        if (cfg_gnt) cg_seen++;
        if (x_eg || x_cg) begin
            check("bram_EN", 32'(bram_EN), 32'h1);
            check("bram_WE", 32'(bram_WE), 32'(x_we));
        end
        if (x_eg) begin
            e.rcyc = cyc + 1; e.data = x_ed; e.err = 1'b0;
            eng_sb.push_back(e);
        end
        if (x_cg) begin
            e.rcyc = cyc + 1; e.data = x_cd; e.err = x_cerr;
            cfg_sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ew, cw, eg0, cg0;
        RST = 1'b1; lock = 1'b0;
        cfg_req = 1'b0; cfg_we = 4'h0; cfg_addr = '0; cfg_wdata = 32'h0;
        eng_req = 1'b0; eng_addr = '0;

        // Reset: requests asserted, yet everything stays quiet.
        repeat (2) @(posedge CLK);
        #1;
        eng_req = 1'b1; cfg_req = 1'b1; cfg_addr = 12'h004;
        #3;
        check("rst_eng_gnt", 32'(eng_gnt), 32'h0);
        check("rst_cfg_gnt", 32'(cfg_gnt), 32'h0);
        check("rst_bram_EN", 32'(bram_EN), 32'h0);
        check("rst_bram_A", 32'(bram_A), 32'h0);
        check("rst_rvalids", {30'b0, cfg_rvalid, eng_rvalid}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // First contention goes to eng, then cfg.
        do_cycle(1, 12'h000, 1, 4'h0, 12'h004, 0, 0, 1, 0, 32'h1000_0000, 0, 0, 4'h0);
        do_cycle(0, 12'h000, 1, 4'h0, 12'h004, 0, 0, 0, 1, 0, 32'h1000_0001, 0, 4'h0);
        idle();

        // Write then immediate engine read of the same word.
        do_cycle(0, 0, 1, 4'hF, 12'h008, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 4'hF);
        do_cycle(1, 12'h008, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 4'h0);
        idle();

        // Partial byte write.
        do_cycle(0, 0, 1, 4'hF, 12'h00C, 32'hAABB_CCDD, 0, 0, 1, 0, 0, 0, 4'hF);
        do_cycle(0, 0, 1, 4'h3, 12'h00C, 32'h1234_5678, 0, 0, 1, 0, 0, 0, 4'h3);
        do_cycle(0, 0, 1, 4'h0, 12'h00C, 0, 0, 0, 1, 0, 32'hAABB_5678, 0, 4'h0);
        idle();

        // Lock holds off a pending write; the engine read shows RAM unchanged.
        for (int i = 0; i < 5; i++)
            do_cycle(i == 2, 12'h010, 1, 4'hF, 12'h010, 32'h5555_5555, 1,
                     i == 2, 0, 32'h1000_0004, 0, 0, 4'h0);
        do_cycle(0, 0, 1, 4'hF, 12'h010, 32'h5555_5555, 0, 0, 1, 0, 0, 0, 4'hF);
        do_cycle(1, 12'h010, 0, 0, 0, 0, 0, 1, 0, 32'h5555_5555, 0, 0, 4'h0);
        // Reads are allowed under lock.
        do_cycle(0, 0, 1, 4'h0, 12'h014, 0, 1, 0, 1, 0, 32'h1000_0005, 0, 4'h0);
        idle();

        // Range check: past the end, write past the end, misaligned, last word.
        do_cycle(0, 0, 1, 4'h0, 12'h030, 0, 0, 0, 1, 0, 0, 1, 4'h0);
        do_cycle(0, 0, 1, 4'hF, 12'h030, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 1, 4'h0);
        do_cycle(0, 0, 1, 4'h0, 12'h005, 0, 0, 0, 1, 0, 0, 1, 4'h0);
        do_cycle(0, 0, 1, 4'h0, 12'h02C, 0, 0, 0, 1, 0, 32'h1000_000B, 0, 4'h0);
        do_cycle(1, 12'h030, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 4'h0);

        // Continuous contention: last winner was eng, so cfg starts.
        eg0 = eg_seen; cg0 = cg_seen;
        for (int i = 0; i < 20; i++) begin
            ew = 5 + (i % 7);
            cw = 11 - (i % 7);
            do_cycle(1, 12'(ew * 4), 1, 4'h0, 12'(cw * 4), 0, 0,
                     (i % 2) == 1, (i % 2) == 0,
                     32'h1000_0000 + 32'(ew), 32'h1000_0000 + 32'(cw), 0, 4'h0);
        end
        check("alt_eng_grants", 32'(eg_seen - eg0), 32'd10);
        check("alt_cfg_grants", 32'(cg_seen - cg0), 32'd10);
        idle();

        // Reset in the return cycle drops the return.
        cfg_req = 1'b1; cfg_we = 4'h0; cfg_addr = 12'h004;
        #3;
        check("pre_rst_cfg_gnt", 32'(cfg_gnt), 32'h1);
        @(posedge CLK);
        #1;
        cfg_req = 1'b0;
        RST = 1'b1;
        #3;
        check("rst_return_cfg_rvalid", 32'(cfg_rvalid), 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle();
        idle();

        check("cfg_queue_drained", 32'(cfg_sb.size()), 32'h0);
        check("eng_queue_drained", 32'(eng_sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tap_bram_arbiter.md
# tap_bram_arbiter

Two-port arbiter and sequencer for the 12-word coefficient BRAM in the FIR datapath. It shares the single BRAM port between the configuration requester (host-side coefficient read/write) and the engine requester (FIR tap fetch, read-only). It also handles the BRAM's one-cycle read latency, range-checks addresses and blocks coefficient writes while the engine holds the lock.

## Interface
Parameters:
- `WORDS`, 12, BRAM depth in 32-bit words; valid byte addresses are 0 to 4*WORDS-4.
- `AW`, 12, address width.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `lock` in 1: engine running; cfg writes are not granted while high.
- `cfg_req` in 1: cfg access request; hold until `cfg_gnt`.
- `cfg_we` in 4: byte write strobes; 0 means read.
- `cfg_addr` in AW: byte address.
- `cfg_wdata` in 32: write data.
- `cfg_gnt` out 1: access accepted this cycle.
- `cfg_rvalid` out 1: `cfg_rdata` valid.
- `cfg_rdata` out 32: read data.
- `cfg_err` out 1: one-cycle pulse; the granted access was out of range.
- `eng_req` in 1: engine read request.
- `eng_addr` in AW: byte address.
- `eng_gnt` out 1: request accepted.
- `eng_rvalid` out 1: `eng_rdata` valid.
- `eng_rdata` out 32: read data.
- `bram_EN`, `bram_WE[3:0]`, `bram_A[AW-1:0]`, `bram_Di[31:0]` out: BRAM port.
- `bram_Do` in 32: BRAM read data, combinational from the registered address and gated by the current `bram_EN`.

## Operation
- At most one grant per cycle. `*_gnt` is combinational from `*_req`, `lock`, and the registered `last` pointer.
- Eligibility:
  - eng is eligible when `eng_req` is high.
  - cfg is eligible when `cfg_req` is high and not (`lock` and `cfg_we` != 0).
  - cfg reads are allowed under lock.
- Arbitration:
  - If both are eligible, grant the one not recorded in `last` (round-robin).
  - `last` updates on every grant.
  - Reset value of `last` is cfg, so eng wins the first contention.
- Granted access drives `bram_EN`=1, `bram_A`=addr, `bram_Di`=wdata (cfg only), and `bram_WE`=strobes. Engine `bram_WE` is always 0.
- Range check: addr[AW-1:2] >= WORDS, or addr[1:0] != 0, is out of range.
  - Out-of-range access is still granted, with `bram_WE` forced to 0.
  - The read returns 0.
  - `cfg_err` pulses in the return cycle (cfg only; engine out-of-range returns 0 silently).
- Return tracking: register `rsel` (none/cfg/eng) and `rbad`, set from the grant cycle.
  - In the next cycle, the selected `*_rvalid`=1.
  - `*_rdata` = `rbad` ? 0 : `bram_Do`.
- `bram_EN` = any grant OR (`rsel` != none). This keeps EN high in the return cycle so `bram_Do` is not gated to 0.
- A cfg write produces `cfg_rvalid` = 1 in the next cycle as a write acknowledge, with `cfg_rdata` = 0.
- Unselected `*_rdata` = 0.
- No buffering; back-to-back grants are allowed, giving one access per cycle of throughput.

## Timing
- Reset values: all outputs 0; `last`=cfg; `rsel`=none; `rbad`=0.
- Grant in cycle N; BRAM samples A/WE at the edge ending N; `rvalid`/`rdata` in N+1.
- Read-after-write to the same address: a cfg write granted in N followed by any read granted in N+1 returns the new data in N+2.
- `lock` rising while a cfg write is requested and not yet granted: the write is held off until `lock` falls. A write granted before the rise completes normally.
- `RST` asserted in the return cycle: `rvalid` is forced to 0 and the return is lost.
- Requester dropping `req` without a grant is legal; no state changes.

## Structure
- Shared package `fir_pkg`:
  - `TAP_WORDS`=12.
  - `ADDR_W`=12.
  - requester enum `{RQ_NONE, RQ_CFG, RQ_ENG}` used for `rsel` and `last`.
- Single module. The grant logic is small enough to stay inline; no sub-module.
- Integration test instantiates `bram12` behind this block.

## Test plan
- After reset, `eng_req`=`cfg_req`=1 (cfg read 0x04) -> `eng_gnt` in cycle 0, `cfg_gnt` in cycle 1, rvalids in cycles 1 and 2.
- cfg write 0x08 <- 0xDEADBEEF with WE=0xF, then eng read 0x08 next cycle -> `eng_rdata`=0xDEADBEEF two cycles after the write grant.
- cfg write WE=0x3, data 0x1234_5678, to a word preloaded with 0xAABBCCDD -> readback 0xAABB5678.
- `lock`=1 with cfg write pending for 5 cycles -> no `cfg_gnt`, RAM unchanged; `lock` falls -> grant in the same cycle.
- cfg read 0x30 -> `cfg_gnt`, then `cfg_rvalid`=1, `cfg_rdata`=0, `cfg_err`=1; cfg write 0x30 -> `bram_WE`=0.
- Continuous `eng_req` and `cfg_req` for 20 cycles -> strictly alternating grants, 10 each, every rvalid one cycle after its grant.
